mem_bus_arbiter: RTL and testbench

// - Shares one single-port synchronous 16-bit memory between the risc16b instruction port (i),
//   the data port (d) and an external loader/DMA port (x), e.g. image preload and result dump.
// - Decodes the IO page (addr[15:8]==IO_PAGE) to a separate IO bus (LED etc.) instead of memory.
// - Sits between the risc16b core and the memory array; gnt low means the requester stalls.

---
 rtl/mem_bus_arbiter_if.sv | 69 ++++++
 rtl/mem_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_if
// Brief   : Requester ports (i/d/x), memory port and IO bus of the arbiter
// Revision: 1.0
// ============================================================================
interface mem_bus_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [15:0] i_rdata;

  logic        d_req;
  logic [15:0] d_addr;
  logic [1:0]  d_we;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;

  logic        x_req;
  logic [15:0] x_addr;
  logic [1:0]  x_we;
  logic [15:0] x_wdata;
  logic        x_lock;
  logic        x_gnt;
  logic        x_rvalid;
  logic [15:0] x_rdata;

  logic        mem_en;
  logic [14:0] mem_addr;
  logic [1:0]  mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        io_en;
  logic [7:0]  io_addr;
  logic [1:0]  io_we;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_addr, d_we, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  x_req, x_addr, x_we, x_wdata, x_lock,
    output x_gnt, x_rvalid, x_rdata,
    output mem_en, mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output io_en, io_addr, io_we, io_wdata,
    input  io_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_addr, d_we, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output x_req, x_addr, x_we, x_wdata, x_lock,
    input  x_gnt, x_rvalid, x_rdata,
    input  mem_en, mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  io_en, io_addr, io_we, io_wdata,
    output io_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares one sync memory between fetch, data and loader ports; IO page decode
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned BURST_MAX    = 8,
  parameter logic [7:0]  IO_PAGE      = 8'h7f
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_X    = 2'd3
  } owner_e;

  localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);
  localparam logic [7:0] c_BURST_MAX    = 8'(BURST_MAX);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        release_q, release_d;
  owner_e      rsp_owner_q, rsp_owner_d;
  logic        rsp_io_q, rsp_io_d;
  logic [15:0] i_hold_q, d_hold_q, x_hold_q;

  logic        w_gnt_i, w_gnt_d, w_gnt_x;
  logic        w_x_top;
  logic        w_active;
  logic        w_sel_io;
  logic [15:0] w_addr;
  logic [1:0]  w_we;
  logic [15:0] w_wdata;
  owner_e      w_owner;
  logic [7:0]  w_burst_inc;
  logic [15:0] w_rsp_data;
  logic        w_rv_i, w_rv_d, w_rv_x;

  // x is lifted above d/i by a locked burst or starvation, except in the forced release cycle
  always_comb begin
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    w_gnt_x = 1'b0;
    w_x_top = !release_q &&
              (((state_q == ST_BURST) && bus.x_lock) || (wait_cnt_q >= c_STARVE_LIMIT));
    if (!rst) begin
      if (w_x_top && bus.x_req) begin
        w_gnt_x = 1'b1;
      end else if (bus.d_req) begin
        w_gnt_d = 1'b1;
      end else if (bus.i_req) begin
        w_gnt_i = 1'b1;
      end else if (bus.x_req) begin
        w_gnt_x = 1'b1;
      end
    end
  end

  always_comb begin
    w_active = 1'b1;
    w_addr   = 16'h0000;
    w_we     = 2'b00;
    w_wdata  = 16'h0000;
    w_owner  = OWN_NONE;
    if (w_gnt_d) begin
      w_addr  = bus.d_addr;
      w_we    = bus.d_we;
      w_wdata = bus.d_wdata;
      w_owner = OWN_D;
    end else if (w_gnt_i) begin
      w_addr  = bus.i_addr;
      w_owner = OWN_I;
    end else if (w_gnt_x) begin
      w_addr  = bus.x_addr;
      w_we    = bus.x_we;
      w_wdata = bus.x_wdata;
      w_owner = OWN_X;
    end else begin
      w_active = 1'b0;
    end
  end

  assign w_sel_io = w_active && (w_addr[15:8] == IO_PAGE);

  assign bus.i_gnt     = w_gnt_i;
  assign bus.d_gnt     = w_gnt_d;
  assign bus.x_gnt     = w_gnt_x;
  assign bus.mem_en    = w_active && !w_sel_io;
  assign bus.mem_addr  = bus.mem_en ? w_addr[15:1] : 15'h0000;
  assign bus.mem_we    = bus.mem_en ? w_we        : 2'b00;
  assign bus.mem_wdata = bus.mem_en ? w_wdata     : 16'h0000;
  assign bus.io_en     = w_sel_io;
  assign bus.io_addr   = w_sel_io ? w_addr[7:0]   : 8'h00;
  assign bus.io_we     = w_sel_io ? w_we          : 2'b00;
  assign bus.io_wdata  = w_sel_io ? w_wdata       : 16'h0000;

  assign w_burst_inc = burst_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    release_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_gnt_x && bus.x_lock) begin
          if (c_BURST_MAX == 8'd1) begin
            release_d = 1'b1;
          end else begin
            state_d     = ST_BURST;
            burst_cnt_d = 8'd1;
          end
        end
      end
      ST_BURST: begin
        if (!bus.x_lock || !bus.x_req) begin
          state_d     = ST_IDLE;
          burst_cnt_d = 8'd0;
        end else if (w_gnt_x) begin
          if (w_burst_inc == c_BURST_MAX) begin
            state_d     = ST_IDLE;
            burst_cnt_d = 8'd0;
            release_d   = 1'b1;
          end else begin
            burst_cnt_d = w_burst_inc;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = 8'd0;
    if (bus.x_req && !w_gnt_x) begin
      wait_cnt_d = (wait_cnt_q == 8'hff) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    rsp_owner_d = OWN_NONE;
    rsp_io_d    = 1'b0;
    if (w_active && (w_we == 2'b00)) begin
      rsp_owner_d = w_owner;
      rsp_io_d    = w_sel_io;
    end
  end

  // Read data is passed through in the response cycle and held in the port register after
  assign w_rsp_data = rsp_io_q ? bus.io_rdata : bus.mem_rdata;
  assign w_rv_i     = !rst && (rsp_owner_q == OWN_I);
  assign w_rv_d     = !rst && (rsp_owner_q == OWN_D);
  assign w_rv_x     = !rst && (rsp_owner_q == OWN_X);

  assign bus.i_rvalid = w_rv_i;
  assign bus.d_rvalid = w_rv_d;
  assign bus.x_rvalid = w_rv_x;
  assign bus.i_rdata  = rst ? 16'h0000 : (w_rv_i ? w_rsp_data : i_hold_q);
  assign bus.d_rdata  = rst ? 16'h0000 : (w_rv_d ? w_rsp_data : d_hold_q);
  assign bus.x_rdata  = rst ? 16'h0000 : (w_rv_x ? w_rsp_data : x_hold_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      burst_cnt_q <= 8'd0;
      release_q   <= 1'b0;
      rsp_owner_q <= OWN_NONE;
      rsp_io_q    <= 1'b0;
      i_hold_q    <= 16'h0000;
      d_hold_q    <= 16'h0000;
      x_hold_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      release_q   <= release_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_io_q    <= rsp_io_d;
      if (w_rv_i) i_hold_q <= w_rsp_data;
      if (w_rv_d) d_hold_q <= w_rsp_data;
      if (w_rv_x) x_hold_q <= w_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Self-checking bench for mem_bus_arbiter with memory/IO models and a reference model
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;
  localparam int STARVE = 15;
  localparam int BMAX   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(
    .STARVE_LIMIT(STARVE),
    .BURST_MAX   (BMAX),
    .IO_PAGE     (8'h7f)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] init_word(int k);
    return 16'(k * 40503) ^ 16'h1234;
  endfunction

  function automatic logic [15:0] init_io(int k);
    return 16'(k * 257) ^ 16'hc3c3;
  endfunction

  // Memory and IO devices: one-cycle read latency, byte lane 0 is the even (high) byte
  logic [15:0] env_mem [0:32767];
  logic [15:0] env_io  [0:255];
  initial begin
    for (int k = 0; k < 32768; k++) env_mem[k] = init_word(k);
    for (int k = 0; k < 256; k++) env_io[k] = init_io(k);
    bus.mem_rdata <= 16'h0000;
    bus.io_rdata  <= 16'h0000;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        bus.mem_rdata <= env_mem[bus.mem_addr];
        if (bus.mem_we[0]) env_mem[bus.mem_addr][15:8] = bus.mem_wdata[15:8];
        if (bus.mem_we[1]) env_mem[bus.mem_addr][7:0]  = bus.mem_wdata[7:0];
      end
      if (bus.io_en) begin
        bus.io_rdata <= env_io[bus.io_addr];
        if (bus.io_we[0]) env_io[bus.io_addr][15:8] = bus.io_wdata[15:8];
        if (bus.io_we[1]) env_io[bus.io_addr][7:0]  = bus.io_wdata[7:0];
      end
    end
  end

  // Reference model state (requester ids: 1=i, 2=d, 3=x, 0=none)
  logic [15:0] sh_mem [0:32767];
  logic [15:0] sh_io  [0:255];
  int          m_wait, m_bcnt, m_owner, e_g;
  bit          m_burst, m_release;
  logic [15:0] m_rsp_data;
  logic [15:0] m_hold [4];

  function automatic bit req_of(int p);
    case (p)
      1: return bus.i_req;
      2: return bus.d_req;
      3: return bus.x_req;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] addr_of(int p);
    case (p)
      1: return bus.i_addr;
      2: return bus.d_addr;
      3: return bus.x_addr;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [1:0] we_of(int p);
    case (p)
      2: return bus.d_we;
      3: return bus.x_we;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [15:0] wdata_of(int p);
    case (p)
      2: return bus.d_wdata;
      3: return bus.x_wdata;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_bcnt = 0; m_burst = 0; m_release = 0; m_owner = 0; e_g = 0;
    m_rsp_data = 16'h0000;
    for (int k = 0; k < 4; k++) m_hold[k] = 16'h0000;
  endtask

  // Pick the first requester in the priority order that the rules give this cycle
  task automatic model_eval();
    int order[3];
    e_g = 0;
    if (!rst) begin
      if (m_release)                                    order = '{2, 1, 3};
      else if ((m_burst && bus.x_lock) || m_wait >= STARVE) order = '{3, 2, 1};
      else                                              order = '{2, 1, 3};
      for (int k = 0; k < 3; k++) if (e_g == 0 && req_of(order[k])) e_g = order[k];
    end
  endtask

  task automatic model_commit();
    logic [15:0] a, wd;
    logic [1:0]  w;
    bit          xg, rel, io;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner != 0) m_hold[m_owner] = m_rsp_data;
    xg  = (e_g == 3);
    rel = 0;
    if (m_burst) begin
      if (!bus.x_lock || !bus.x_req) begin
        m_burst = 0; m_bcnt = 0;
      end else if (xg) begin
        m_bcnt++;
        if (m_bcnt == BMAX) begin m_burst = 0; m_bcnt = 0; rel = 1; end
      end
    end else if (xg && bus.x_lock) begin
      m_burst = 1; m_bcnt = 1;
    end
    m_release = rel;
    m_wait    = (bus.x_req && !xg) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
    m_owner   = 0;
    if (e_g != 0) begin
      a  = addr_of(e_g);
      w  = we_of(e_g);
      wd = wdata_of(e_g);
      io = (a[15:8] == 8'h7f);
      if (w == 2'b00) begin
        m_owner    = e_g;
        m_rsp_data = io ? sh_io[a[7:0]] : sh_mem[a[15:1]];
      end else if (io) begin
        if (w[0]) sh_io[a[7:0]][15:8] = wd[15:8];
        if (w[1]) sh_io[a[7:0]][7:0]  = wd[7:0];
      end else begin
        if (w[0]) sh_mem[a[15:1]][15:8] = wd[15:8];
        if (w[1]) sh_mem[a[15:1]][7:0]  = wd[7:0];
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] a, wd, er;
    logic [1:0]  w;
    bit          act, io;
    act = (e_g != 0);
    a   = addr_of(e_g);
    w   = we_of(e_g);
    wd  = wdata_of(e_g);
    io  = act && (a[15:8] == 8'h7f);
    chk("gnt_dix", 32'({bus.d_gnt, bus.i_gnt, bus.x_gnt}), 32'({e_g == 2, e_g == 1, e_g == 3}));
    chk("mem_en", 32'(bus.mem_en), 32'(act && !io));
    chk("mem_addr", 32'(bus.mem_addr), 32'((act && !io) ? a[15:1] : 15'h0));
    chk("mem_we", 32'(bus.mem_we), 32'((act && !io) ? w : 2'b00));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'((act && !io) ? wd : 16'h0));
    chk("io_en", 32'(bus.io_en), 32'(io));
    chk("io_addr", 32'(bus.io_addr), 32'(io ? a[7:0] : 8'h0));
    chk("io_we", 32'(bus.io_we), 32'(io ? w : 2'b00));
    chk("io_wdata", 32'(bus.io_wdata), 32'(io ? wd : 16'h0));
    chk("rvalid_dix", 32'({bus.d_rvalid, bus.i_rvalid, bus.x_rvalid}),
        32'({!rst && m_owner == 2, !rst && m_owner == 1, !rst && m_owner == 3}));
    er = rst ? 16'h0 : ((m_owner == 1) ? m_rsp_data : m_hold[1]);
    chk("i_rdata", 32'(bus.i_rdata), 32'(er));
    er = rst ? 16'h0 : ((m_owner == 2) ? m_rsp_data : m_hold[2]);
    chk("d_rdata", 32'(bus.d_rdata), 32'(er));
    er = rst ? 16'h0 : ((m_owner == 3) ? m_rsp_data : m_hold[3]);
    chk("x_rdata", 32'(bus.x_rdata), 32'(er));
  endtask

  task automatic tick_a();
    @(negedge clk);
    model_eval();
    compare_all();
  endtask

  task automatic tick_b();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  task automatic idle_inputs();
    bus.i_req = 0; bus.i_addr = 16'h0;
    bus.d_req = 0; bus.d_addr = 16'h0; bus.d_we = 2'b00; bus.d_wdata = 16'h0;
    bus.x_req = 0; bus.x_addr = 16'h0; bus.x_we = 2'b00; bus.x_wdata = 16'h0; bus.x_lock = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? {8'h7f, 8'($urandom)} : 16'($urandom);
  endfunction

  task automatic rand_reqs();
    if (e_g == 1 || !bus.i_req) begin
      bus.i_req  = ($urandom_range(0, 2) != 0);
      bus.i_addr = rand_addr();
    end
    if (e_g == 2 || !bus.d_req) begin
      bus.d_req   = ($urandom_range(0, 2) != 0);
      bus.d_addr  = rand_addr();
      bus.d_we    = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.d_wdata = 16'($urandom);
    end
    if (e_g == 3 || !bus.x_req) begin
      bus.x_req   = ($urandom_range(0, 2) != 0);
      bus.x_addr  = rand_addr();
      bus.x_we    = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.x_wdata = 16'($urandom);
    end
    if ($urandom_range(0, 7) == 0) bus.x_lock = ~bus.x_lock;
  endtask

  typedef struct {
    logic [2:0]  req;       // {d, i, x}
    logic [15:0] d_addr;
    logic [15:0] i_addr;
    logic [15:0] x_addr;
    logic [1:0]  d_we;
    logic [1:0]  x_we;
    logic [15:0] wdata;
    logic [2:0]  gnt;       // {d, i, x}
    logic        mem_en;
    logic        io_en;
    logic [15:0] out_addr;  // mem_addr when mem_en, else io_addr
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n, xc;
    bit got, done;
    logic [15:0] w0, exp_w;
    logic [15:0] out_a;

    tbl[0] = '{3'b111, 16'h0010, 16'h0020, 16'h0030, 2'b00, 2'b00, 16'h0000, 3'b100, 1'b1, 1'b0, 16'h0008};
    tbl[1] = '{3'b010, 16'h0000, 16'h0020, 16'h0000, 2'b00, 2'b00, 16'h0000, 3'b010, 1'b1, 1'b0, 16'h0010};
    tbl[2] = '{3'b001, 16'h0000, 16'h0000, 16'h0031, 2'b00, 2'b00, 16'h0000, 3'b001, 1'b1, 1'b0, 16'h0018};
    tbl[3] = '{3'b100, 16'h7f00, 16'h0000, 16'h0000, 2'b11, 2'b00, 16'h00a5, 3'b100, 1'b0, 1'b1, 16'h0000};
    tbl[4] = '{3'b011, 16'h0000, 16'h0040, 16'h0050, 2'b00, 2'b00, 16'h0000, 3'b010, 1'b1, 1'b0, 16'h0020};
    tbl[5] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0000};
    tbl[6] = '{3'b100, 16'hc001, 16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000, 3'b100, 1'b1, 1'b0, 16'h6000};
    tbl[7] = '{3'b101, 16'h0100, 16'h0000, 16'h7f42, 2'b00, 2'b01, 16'h1234, 3'b100, 1'b1, 1'b0, 16'h0080};
    tbl[8] = '{3'b001, 16'h0000, 16'h0000, 16'h7f42, 2'b00, 2'b01, 16'h1234, 3'b001, 1'b0, 1'b1, 16'h0042};

    for (int k = 0; k < 32768; k++) sh_mem[k] = init_word(k);
    for (int k = 0; k < 256; k++) sh_io[k] = init_io(k);
    model_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Single-cycle vectors from a freshly reset arbiter
    for (int v = 0; v < 9; v++) begin
      pulse_reset();
      {bus.d_req, bus.i_req, bus.x_req} = tbl[v].req;
      bus.d_addr = tbl[v].d_addr; bus.i_addr = tbl[v].i_addr; bus.x_addr = tbl[v].x_addr;
      bus.d_we = tbl[v].d_we; bus.x_we = tbl[v].x_we;
      bus.d_wdata = tbl[v].wdata; bus.x_wdata = tbl[v].wdata;
      tick_a();
      out_a = tbl[v].mem_en ? {1'b0, bus.mem_addr} : {8'h00, bus.io_addr};
      chk($sformatf("tbl%0d_gnt", v), 32'({bus.d_gnt, bus.i_gnt, bus.x_gnt}), 32'(tbl[v].gnt));
      chk($sformatf("tbl%0d_mem_en", v), 32'(bus.mem_en), 32'(tbl[v].mem_en));
      chk($sformatf("tbl%0d_io_en", v), 32'(bus.io_en), 32'(tbl[v].io_en));
      chk($sformatf("tbl%0d_addr", v), 32'(out_a), 32'(tbl[v].out_addr));
      tick_b();
      idle_inputs();
      tick();
    end

    // Three simultaneous reads drain d, i, x in order with latency 1
    pulse_reset();
    bus.d_req = 1; bus.d_addr = 16'h0010;
    bus.i_req = 1; bus.i_addr = 16'h0020;
    bus.x_req = 1; bus.x_addr = 16'h0030;
    tick_a(); chk("seq3_d_gnt", 32'(bus.d_gnt), 32'd1); tick_b();
    bus.d_req = 0;
    tick_a();
    chk("seq3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("seq3_d_rdata", 32'(bus.d_rdata), 32'(init_word(16'h0008)));
    chk("seq3_i_gnt", 32'(bus.i_gnt), 32'd1);
    tick_b();
    bus.i_req = 0;
    tick_a();
    chk("seq3_i_rdata", 32'(bus.i_rdata), 32'(init_word(16'h0010)));
    chk("seq3_x_gnt", 32'(bus.x_gnt), 32'd1);
    tick_b();
    bus.x_req = 0;
    tick_a(); chk("seq3_x_rdata", 32'(bus.x_rdata), 32'(init_word(16'h0018))); tick_b();

    // IO-page write produces no read response
    bus.d_req = 1; bus.d_addr = 16'h7f00; bus.d_we = 2'b11; bus.d_wdata = 16'h00a5;
    tick_a(); chk("io_wr_io_en", 32'(bus.io_en), 32'd1); tick_b();
    idle_inputs();
    tick_a(); chk("io_wr_no_rvalid", 32'(bus.d_rvalid), 32'd0); tick_b();

    // Starvation: x overtakes a continuously requesting i
    pulse_reset();
    bus.i_req = 1; bus.i_addr = 16'h0100;
    bus.x_req = 1; bus.x_addr = 16'h0200;
    n = 0; got = 0;
    while (!got && n < 40) begin
      tick_a();
      if (bus.x_gnt) got = 1; else n++;
      tick_b();
    end
    chk("starve_wait_cycles", 32'(n), 32'(STARVE));
    idle_inputs();
    tick();

    // Locked burst is capped, d gets the release cycle, then x resumes
    pulse_reset();
    bus.x_req = 1; bus.x_lock = 1; bus.x_addr = 16'h0300;
    tick();
    bus.d_req = 1; bus.d_addr = 16'h0400;
    xc = 1; done = 0; n = 0;
    while (!done && n < 30) begin
      tick_a();
      if (bus.x_gnt) xc++;
      if (bus.d_gnt) done = 1;
      n++;
      tick_b();
    end
    chk("burst_x_grants", 32'(xc), 32'(BMAX));
    chk("burst_d_granted", 32'(done), 32'd1);
    bus.d_req = 0;
    tick_a(); chk("burst_x_resume", 32'(bus.x_gnt), 32'd1); tick_b();

    // Reset in the middle of a burst drops the lock and the pending response
    tick();
    rst = 1'b1;
    tick_a();
    chk("rst_gnt", 32'({bus.d_gnt, bus.i_gnt, bus.x_gnt}), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_x_rvalid", 32'(bus.x_rvalid), 32'd0);
    tick_b();
    rst = 1'b0;
    bus.d_req = 1; bus.d_addr = 16'h0500;
    tick_a();
    chk("post_rst_d_wins", 32'({bus.d_gnt, bus.x_gnt}), 32'b10);
    chk("post_rst_x_rvalid", 32'(bus.x_rvalid), 32'd0);
    tick_b();
    idle_inputs();
    tick();

    // Byte-lane write then odd-address read
    bus.x_req = 1; bus.x_addr = 16'hc000; bus.x_we = 2'b01; bus.x_wdata = 16'hbeef;
    tick();
    idle_inputs();
    bus.d_req = 1; bus.d_addr = 16'hc001;
    tick_a(); chk("byte_rd_mem_addr", 32'(bus.mem_addr), 32'h6000); tick_b();
    idle_inputs();
    w0 = init_word(16'h6000);
    exp_w = {8'hbe, w0[7:0]};
    tick_a(); chk("byte_rd_data", 32'(bus.d_rdata), 32'(exp_w)); tick_b();

    // Randomised traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      tick();
      rand_reqs();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected the test to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
